sram_resp: RTL and testbench
============================

SRAM_RESP -- requirements
Module: sram_resp

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 10, giving word-index bits; DEPTH = 2^ADDR_W 32-bit words.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port resetn, input, 1, reset that is asynchronous and active-low.
REQ-004 The module SHALL have port sram_en, input, 1, access request for this cycle.
REQ-005 The module SHALL have port sram_we, input, 4, byte write strobes; bit i enables byte lane i (bits 8i+7:8i).
REQ-006 The module SHALL have port sram_addr, input, 32, byte address; bits 1:0 are ignored.
REQ-007 The module SHALL have port sram_wdata, input, 32, write data.
REQ-008 The module SHALL have port sram_rdata, output, 32, registered read data.
REQ-009 The module SHALL have port oor_err, output, 1, sticky out-of-range access flag.
REQ-010 The module SHALL have port err_clr, input, 1, clears oor_err.
REQ-011 The module SHALL have ports rd_cnt and wr_cnt, both output, 32, access counters; they are present only under SRAM_RESP_CNT_EN.

Function
REQ-012 The module SHALL treat an access as in-range when sram_addr[31:ADDR_W+2] == 0; the word index is sram_addr[ADDR_W+1:2].
REQ-013 The module SHALL, when sram_en=1 and the access is in-range, load sram_rdata at the next rising edge with the word's value from before any write in that same cycle (read-first).
REQ-014 The module SHALL, when sram_en=1, the access is in-range and sram_we!=0, update only the strobed byte lanes at that edge; unstrobed lanes keep their values.
REQ-015 The module SHALL hold sram_rdata unchanged in cycles with sram_en=0.
REQ-016 The module SHALL, when sram_en=1 and the access is out-of-range, perform no write, load sram_rdata with 0x00000000, and set oor_err to 1 at that edge.
REQ-017 The module SHALL keep oor_err at 1 until err_clr=1 is sampled; if an error is set and err_clr is sampled in the same cycle, set SHALL win.
REQ-018 The module SHALL have a read latency of exactly 1 cycle and SHALL accept back-to-back accesses every cycle with no stall.
REQ-019 The module SHALL, when a write and a read to the same word occur in consecutive cycles, return the newly written bytes on the read.
REQ-020 The module SHALL leave memory contents uninitialised and unaffected by reset.

Reset
REQ-021 The module SHALL, while resetn=0, force sram_rdata=0, oor_err=0, rd_cnt=0 and wr_cnt=0 immediately, independent of clk.
REQ-022 The module SHALL ignore any access request in a cycle where resetn=0 at the clock edge, so that no write and no counter update occur.
REQ-023 The module SHALL honour the first access on the first rising edge after resetn deasserts.

Configuration
REQ-024 The module SHALL, when macro SRAM_RESP_CNT_EN is defined, increment rd_cnt on each accepted access with sram_en=1 and sram_we=0, and increment wr_cnt on each accepted access with sram_en=1 and sram_we!=0; out-of-range accesses are counted.
REQ-025 The module SHALL saturate both counters at 0xFFFFFFFF with no wrap-around.
REQ-026 The module SHALL, when SRAM_RESP_CNT_EN is not defined, omit the rd_cnt/wr_cnt ports and the counter logic, with all other behaviour unchanged.

Verification
REQ-027 The bench SHALL check: write 0x12345678 with we=0xF to addr 0x10, then read 0x10 -> sram_rdata=0x12345678 one cycle after the read.
REQ-028 The bench SHALL check: after the REQ-027 write, write 0x0000AB00 with we=0x2 to 0x10, then read -> 0x1234AB78.
REQ-029 The bench SHALL check: with ADDR_W=10, read addr 0x00001000 -> sram_rdata=0, oor_err=1, no memory change; assert err_clr for 1 cycle -> oor_err=0; an out-of-range access together with err_clr -> oor_err stays 1.
REQ-030 The bench SHALL check: a write to 0x20 followed by a read of 0x20 in the next cycle -> new data; a read-first write in the same cycle as the read -> old data; sram_en=0 for 3 cycles -> sram_rdata held.
REQ-031 The bench SHALL check: assert resetn=0 between clock edges during a write stream -> sram_rdata and oor_err go to 0 immediately; the write sampled during reset is not applied.
REQ-032 The bench SHALL check, with SRAM_RESP_CNT_EN defined: 5 reads and 3 writes -> rd_cnt=5, wr_cnt=3; force rd_cnt to 0xFFFFFFFF, then 1 more read -> it stays 0xFFFFFFFF.

Source files
------------

// File: rtl/sram_resp.sv
// sram_resp: single-port word SRAM with byte strobes, registered read data
// (read-first, 1-cycle latency) and a sticky out-of-range error flag.
// Optional access counters rd_cnt/wr_cnt are built when SRAM_RESP_CNT_EN
// is defined; the default build omits them and their ports.
module sram_resp #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_en,
  input  logic [3:0]  sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        oor_err,
  input  logic        err_clr
`ifdef SRAM_RESP_CNT_EN
  ,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  // Storage is deliberately not reset; contents are undefined until written.
  logic [31:0] mem [DEPTH];

  logic              in_range;
  logic [ADDR_W-1:0] word_idx;
  logic              mem_wr;

  logic [31:0] rdata_d, rdata_q;
  logic        oor_err_d, oor_err_q;

  // Address decode: any set bit above the word index makes the access out of range.
  always_comb begin
    in_range = ((sram_addr >> (ADDR_W + 2)) == 32'd0);
    word_idx = sram_addr[ADDR_W+1:2];
    mem_wr   = sram_en && in_range && (sram_we != 4'b0000);
  end

  // Next read data: old word contents (read-first), zero when out of range, hold when idle.
  always_comb begin
    rdata_d = rdata_q;
    if (sram_en) begin
      if (in_range) begin
        rdata_d = mem[word_idx];
      end else begin
        rdata_d = '0;
      end
    end
  end

  // Sticky error: a new out-of-range access takes priority over a clear.
  always_comb begin
    oor_err_d = oor_err_q;
    if (sram_en && !in_range) begin
      oor_err_d = 1'b1;
    end else if (err_clr) begin
      oor_err_d = 1'b0;
    end
  end

  // Output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q   <= '0;
      oor_err_q <= 1'b0;
    end else begin
      rdata_q   <= rdata_d;
      oor_err_q <= oor_err_d;
    end
  end

  // Byte-lane writes; an edge sampled while resetn is low applies no write.
  always_ff @(posedge clk) begin
    if (resetn && mem_wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (sram_we[i]) begin
          mem[word_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
        end
      end
    end
  end

  assign sram_rdata = rdata_q;
  assign oor_err    = oor_err_q;

`ifdef SRAM_RESP_CNT_EN
  logic [31:0] rd_cnt_d, rd_cnt_q;
  logic [31:0] wr_cnt_d, wr_cnt_q;

  // Saturating access counters; out-of-range accesses are counted too.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (sram_en) begin
      if (sram_we == 4'b0000) begin
        if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 32'd1;
      end else begin
        if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 32'd1;
      end
    end
  end

  // Counter registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_sram_resp.sv
// Directed self-checking bench for sram_resp (ADDR_W = 10).
// Counter checks are compiled in when SRAM_RESP_CNT_EN is defined.
module tb_sram_resp;

  logic        clk;
  logic        resetn;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        oor_err;
  logic        err_clr;
`ifdef SRAM_RESP_CNT_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
`endif

  int checks = 0;
  int errors = 0;

  sram_resp #(.ADDR_W(10)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .oor_err    (oor_err),
    .err_clr    (err_clr)
`ifdef SRAM_RESP_CNT_EN
    ,
    .rd_cnt     (rd_cnt),
    .wr_cnt     (wr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic acc(input logic en, input logic [3:0] we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic clr);
    sram_en    = en;
    sram_we    = we;
    sram_addr  = addr;
    sram_wdata = wdata;
    err_clr    = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; sram_en = 1'b0; sram_we = 4'h0;
    sram_addr = '0; sram_wdata = '0; err_clr = 1'b0;

    #12;
    check("reset_rdata", sram_rdata, 32'h0);
    check("reset_oor", {31'd0, oor_err}, 32'h0);

    @(negedge clk);
    resetn = 1'b1;

    // Full-word write on the first edge after reset, then read back.
    acc(1'b1, 4'hF, 32'h10, 32'h12345678, 1'b0);
    acc(1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
    check("full_write_read", sram_rdata, 32'h12345678);

    // Single-lane write on byte 1.
    acc(1'b1, 4'h2, 32'h10, 32'h0000AB00, 1'b0);
    check("partial_write_old", sram_rdata, 32'h12345678);
    acc(1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
    check("partial_write_read", sram_rdata, 32'h1234AB78);

    // Out of range: 0x1000 would alias word 0 if the upper bits were dropped.
    acc(1'b1, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0);
    acc(1'b1, 4'hF, 32'h00001000, 32'hDEADBEEF, 1'b0);
    check("oor_rdata", sram_rdata, 32'h0);
    check("oor_flag", {31'd0, oor_err}, 32'h1);
    acc(1'b1, 4'h0, 32'h00001000, 32'h0, 1'b0);
    check("oor_read_rdata", sram_rdata, 32'h0);
    acc(1'b1, 4'h0, 32'h0, 32'h0, 1'b0);
    check("oor_no_write", sram_rdata, 32'hCAFEF00D);
    check("oor_sticky", {31'd0, oor_err}, 32'h1);
    acc(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    check("oor_clear", {31'd0, oor_err}, 32'h0);
    check("idle_hold_after_clr", sram_rdata, 32'hCAFEF00D);
    acc(1'b1, 4'h0, 32'h00001000, 32'h0, 1'b1);
    check("oor_set_wins", {31'd0, oor_err}, 32'h1);
    acc(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    check("oor_clear2", {31'd0, oor_err}, 32'h0);

    // Write then read next cycle, then a read-first write, then idle hold.
    acc(1'b1, 4'hF, 32'h20, 32'hA5A5A5A5, 1'b0);
    acc(1'b1, 4'h0, 32'h20, 32'h0, 1'b0);
    check("wr_then_rd", sram_rdata, 32'hA5A5A5A5);
    acc(1'b1, 4'hF, 32'h20, 32'h5A5A5A5A, 1'b0);
    check("read_first", sram_rdata, 32'hA5A5A5A5);
    acc(1'b1, 4'h0, 32'h20, 32'h0, 1'b0);
    check("after_rf_write", sram_rdata, 32'h5A5A5A5A);
    for (int i = 0; i < 3; i++) begin
      acc(1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
      check($sformatf("idle_hold_%0d", i), sram_rdata, 32'h5A5A5A5A);
    end

    // Asynchronous reset in the middle of a write stream.
    acc(1'b1, 4'hF, 32'h30, 32'h11111111, 1'b0);
    acc(1'b1, 4'hF, 32'h30, 32'h22222222, 1'b0);
    check("stream_old", sram_rdata, 32'h11111111);
    acc(1'b1, 4'h0, 32'h00002000, 32'h0, 1'b0);
    acc(1'b1, 4'hF, 32'h30, 32'h22222222, 1'b0);
    check("stream_pre_reset", sram_rdata, 32'h22222222);
    check("stream_pre_reset_oor", {31'd0, oor_err}, 32'h1);
    sram_wdata = 32'h33333333;
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_rdata", sram_rdata, 32'h0);
    check("async_rst_oor", {31'd0, oor_err}, 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold_rdata", sram_rdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    sram_en = 1'b0;
    acc(1'b1, 4'h0, 32'h30, 32'h0, 1'b0);
    check("write_in_reset_dropped", sram_rdata, 32'h22222222);

`ifdef SRAM_RESP_CNT_EN
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("cnt_rst_rd", rd_cnt, 32'd0);
    check("cnt_rst_wr", wr_cnt, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) acc(1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) acc(1'b1, 4'h1, 32'h40, i, 1'b0);
    sram_en = 1'b0;
    check("rd_cnt_5", rd_cnt, 32'd5);
    check("wr_cnt_3", wr_cnt, 32'd3);
    force dut.rd_cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.rd_cnt_q;
    acc(1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
    sram_en = 1'b0;
    check("rd_cnt_sat", rd_cnt, 32'hFFFFFFFF);
    check("wr_cnt_unchanged", wr_cnt, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
